rv64g_l1_vec_req_queue: RTL and testbench

RV64G_L1_VEC_REQ_QUEUE -- requirements
Module: rv64g_l1_vec_req_queue

---
 rtl/rv64g_l1_vec_req_queue_pkg.sv | 26 ++
 rtl/rv64g_l1_vec_req_queue_fifo.sv | 66 ++++++
 rtl/rv64g_l1_vec_req_queue.sv | 155 +++++++++++++++
 tb/tb_rv64g_l1_vec_req_queue.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv64g_l1_vec_req_queue_pkg.sv
// -----------------------------------------------------------------------------
// rv64g_l1_vec_req_queue_pkg
//   Shared constants for the L1 vector request queue: payload field widths,
//   parameter defaults and the packed payload width helper.
// -----------------------------------------------------------------------------
package rv64g_l1_vec_req_queue_pkg;

    // Fixed payload field widths
    localparam int WORD_W = 3;
    localparam int WAY_W  = 3;
    localparam int BE_W   = 8;
    localparam int DATA_W = 64;

    // Parameter defaults
    localparam int DEF_TAG_W        = 53;
    localparam int DEF_INDEX_W      = 5;
    localparam int DEF_DEPTH        = 4;
    localparam int DEF_ID_W         = 4;
    localparam int DEF_STARVE_LIMIT = 16;

    // Width of one queue entry: {we, index, word, way, be, wdata, id}
    function automatic int payload_w(input int index_w, input int id_w);
        return 1 + index_w + WORD_W + WAY_W + BE_W + DATA_W + id_w;
    endfunction

endpackage

// File: rtl/rv64g_l1_vec_req_queue_fifo.sv
// -----------------------------------------------------------------------------
// rv64g_l1_sync_fifo
//   Generic circular FIFO: storage array, head/tail pointers wrapping modulo
//   DEPTH (power of two), separate occupancy counter, synchronous flush.
//   The caller guarantees no push when full and no pop when empty.
//
// Ports
//   clk, rst_n     clock, asynchronous active-low reset
//   push, pop      write at tail / advance head
//   flush          discard all entries (overrides push and pop)
//   wdata          entry written on push
//   rdata          entry at head (undefined when empty)
//   count          current occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module rv64g_l1_sync_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            // Pointers are exactly PTR_W bits wide, so overflow is the wrap.
            if (push) tail <= tail + 1'b1;
            if (pop)  head <= head + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: the storage array has no reset; occupancy alone decides which
    // entries are meaningful, so clearing the data would only cost flops.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[tail] <= wdata;
    end

    assign rdata = mem[head];

endmodule

// File: rtl/rv64g_l1_vec_req_queue.sv
// -----------------------------------------------------------------------------
// rv64g_l1_vec_req_queue
//   Request queue between a vector lane and the L1 bank arbiter vector port.
//   Requests are buffered in order; the head is presented to the arbiter with
//   zero latency and retried every cycle while stalled. A grant returns a
//   registered completion one cycle later, with bank read data passed through
//   for reads. A saturating counter flags a head that has been stalled for
//   STARVE_LIMIT consecutive cycles.
//
// Ports
//   clk_i, rst_ni                      clock, asynchronous active-low reset
//   in_valid_i / in_ready_o            lane request handshake
//   in_we_i .. in_id_i                 lane request payload
//   vec_req_o, vec_we_o .. vec_wdata_o head request to arbiter (zero if empty)
//   vec_stall_i                        arbiter stall for the vector port
//   bank_rdata_i                       bank read data, cycle after grant
//   flush_i                            synchronous discard of all entries
//   rsp_valid_o, rsp_we_o, rsp_id_o,
//   rsp_rdata_o                        completion to the lane
//   starve_o                           head stalled STARVE_LIMIT cycles
//   count_o                            current occupancy
// -----------------------------------------------------------------------------
module rv64g_l1_vec_req_queue
    import rv64g_l1_vec_req_queue_pkg::*;
#(
    parameter int TAG_W        = DEF_TAG_W,
    parameter int INDEX_W      = DEF_INDEX_W,
    parameter int DEPTH        = DEF_DEPTH,
    parameter int ID_W         = DEF_ID_W,
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic                   in_we_i,
    input  logic [INDEX_W-1:0]     in_index_i,
    input  logic [WORD_W-1:0]      in_word_i,
    input  logic [WAY_W-1:0]       in_way_i,
    input  logic [BE_W-1:0]        in_be_i,
    input  logic [DATA_W-1:0]      in_wdata_i,
    input  logic [ID_W-1:0]        in_id_i,
    output logic                   vec_req_o,
    output logic                   vec_we_o,
    output logic [INDEX_W-1:0]     vec_index_o,
    output logic [WORD_W-1:0]      vec_word_o,
    output logic [WAY_W-1:0]       vec_way_o,
    output logic [BE_W-1:0]        vec_be_o,
    output logic [DATA_W-1:0]      vec_wdata_o,
    input  logic                   vec_stall_i,
    input  logic [DATA_W-1:0]      bank_rdata_i,
    input  logic                   flush_i,
    output logic                   rsp_valid_o,
    output logic                   rsp_we_o,
    output logic [ID_W-1:0]        rsp_id_o,
    output logic [DATA_W-1:0]      rsp_rdata_o,
    output logic                   starve_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int PAYLOAD_W = payload_w(INDEX_W, ID_W);
    localparam int CNT_W     = $clog2(DEPTH) + 1;
    localparam int STARVE_W  = $clog2(STARVE_LIMIT + 1);

    localparam logic [CNT_W-1:0]    DEPTH_C = CNT_W'(DEPTH);
    localparam logic [STARVE_W-1:0] LIMIT_C = STARVE_W'(STARVE_LIMIT);

    // TAG_W travels with the bundle but has no function here; it is only
    // sanity-checked together with the parameters that do matter.
    if (TAG_W < 1 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || STARVE_LIMIT < 1)
    begin : g_bad_params
        $error("rv64g_l1_vec_req_queue: illegal parameter set");
    end

    logic                 push;
    logic                 pop;
    logic [PAYLOAD_W-1:0] head_data;
    logic                 h_we;
    logic [INDEX_W-1:0]   h_index;
    logic [WORD_W-1:0]    h_word;
    logic [WAY_W-1:0]     h_way;
    logic [BE_W-1:0]      h_be;
    logic [DATA_W-1:0]    h_wdata;
    logic [ID_W-1:0]      h_id;
    logic                 rsp_we_q;
    logic [ID_W-1:0]      rsp_id_q;
    logic [STARVE_W-1:0]  starve_cnt;

    // Ready depends only on occupancy, so a full queue never accepts a push
    // even when the head is being granted in the same cycle.
    assign in_ready_o = (count_o < DEPTH_C) && !flush_i;
    assign push       = in_valid_i && in_ready_o;
    assign vec_req_o  = (count_o != '0);
    assign pop        = vec_req_o && !vec_stall_i && !flush_i;

    rv64g_l1_sync_fifo #(
        .WIDTH (PAYLOAD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk_i),
        .rst_n (rst_ni),
        .push  (push),
        .pop   (pop),
        .flush (flush_i),
        .wdata ({in_we_i, in_index_i, in_word_i, in_way_i, in_be_i, in_wdata_i, in_id_i}),
        .rdata (head_data),
        .count (count_o)
    );

    assign {h_we, h_index, h_word, h_way, h_be, h_wdata, h_id} = head_data;

    // Storage beyond the occupancy is stale, so the payload is forced to zero
    // whenever there is no request.
    assign vec_we_o    = vec_req_o && h_we;
    assign vec_index_o = vec_req_o ? h_index : '0;
    assign vec_word_o  = vec_req_o ? h_word  : '0;
    assign vec_way_o   = vec_req_o ? h_way   : '0;
    assign vec_be_o    = vec_req_o ? h_be    : '0;
    assign vec_wdata_o = vec_req_o ? h_wdata : '0;

    // Completion tracks the grant one cycle later. Flush never cancels it:
    // a grant from the previous cycle is already in flight.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rsp_valid_o <= 1'b0;
            rsp_we_q    <= 1'b0;
            rsp_id_q    <= '0;
        end else begin
            rsp_valid_o <= pop;
            if (pop) begin
                rsp_we_q <= h_we;
                rsp_id_q <= h_id;
            end
        end
    end

    assign rsp_we_o    = rsp_valid_o && rsp_we_q;
    assign rsp_id_o    = rsp_valid_o ? rsp_id_q : '0;
    assign rsp_rdata_o = (rsp_valid_o && !rsp_we_q) ? bank_rdata_i : '0;

    // Counts consecutive stalled cycles of the current head; any grant, an
    // empty queue or a flush restarts it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            starve_cnt <= '0;
        end else if (flush_i || pop || !vec_req_o) begin
            starve_cnt <= '0;
        end else if (vec_stall_i && starve_cnt != LIMIT_C) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    assign starve_o = (starve_cnt == LIMIT_C);

endmodule

// File: tb/tb_rv64g_l1_vec_req_queue.sv
// -----------------------------------------------------------------------------
// tb_rv64g_l1_vec_req_queue
//   Directed scenarios followed by randomized traffic, all compared every
//   cycle against a queue-based reference model of the request queue.
// -----------------------------------------------------------------------------
module tb_rv64g_l1_vec_req_queue;
    import rv64g_l1_vec_req_queue_pkg::*;

    localparam int INDEX_W      = 5;
    localparam int ID_W         = 4;
    localparam int DEPTH        = 4;
    localparam int STARVE_LIMIT = 16;

    typedef struct packed {
        logic               we;
        logic [INDEX_W-1:0] index;
        logic [WORD_W-1:0]  word;
        logic [WAY_W-1:0]   way;
        logic [BE_W-1:0]    be;
        logic [DATA_W-1:0]  wdata;
        logic [ID_W-1:0]    id;
    } req_t;

    logic                   clk_i = 1'b0;
    logic                   rst_ni;
    logic                   in_valid_i;
    logic                   in_ready_o;
    req_t                   drv;
    logic                   vec_req_o;
    logic                   vec_we_o;
    logic [INDEX_W-1:0]     vec_index_o;
    logic [WORD_W-1:0]      vec_word_o;
    logic [WAY_W-1:0]       vec_way_o;
    logic [BE_W-1:0]        vec_be_o;
    logic [DATA_W-1:0]      vec_wdata_o;
    logic                   vec_stall_i;
    logic [DATA_W-1:0]      bank_rdata_i;
    logic                   flush_i;
    logic                   rsp_valid_o;
    logic                   rsp_we_o;
    logic [ID_W-1:0]        rsp_id_o;
    logic [DATA_W-1:0]      rsp_rdata_o;
    logic                   starve_o;
    logic [$clog2(DEPTH):0] count_o;

    always #5 clk_i = ~clk_i;

    rv64g_l1_vec_req_queue #(
        .TAG_W        (53),
        .INDEX_W      (INDEX_W),
        .DEPTH        (DEPTH),
        .ID_W         (ID_W),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .in_valid_i   (in_valid_i),
        .in_ready_o   (in_ready_o),
        .in_we_i      (drv.we),
        .in_index_i   (drv.index),
        .in_word_i    (drv.word),
        .in_way_i     (drv.way),
        .in_be_i      (drv.be),
        .in_wdata_i   (drv.wdata),
        .in_id_i      (drv.id),
        .vec_req_o    (vec_req_o),
        .vec_we_o     (vec_we_o),
        .vec_index_o  (vec_index_o),
        .vec_word_o   (vec_word_o),
        .vec_way_o    (vec_way_o),
        .vec_be_o     (vec_be_o),
        .vec_wdata_o  (vec_wdata_o),
        .vec_stall_i  (vec_stall_i),
        .bank_rdata_i (bank_rdata_i),
        .flush_i      (flush_i),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_we_o     (rsp_we_o),
        .rsp_id_o     (rsp_id_o),
        .rsp_rdata_o  (rsp_rdata_o),
        .starve_o     (starve_o),
        .count_o      (count_o)
    );

    // Reference model state
    req_t  model_q[$];
    int    model_starve;
    bit    model_rsp_valid;
    req_t  model_rsp;

    int    vectors     = 0;
    int    miscompares = 0;
    string phase       = "init";

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s/%s: got %0h expected %0h", phase, tag, got, exp);
        end
    endtask

    task automatic model_reset();
        model_q.delete();
        model_starve    = 0;
        model_rsp_valid = 1'b0;
        model_rsp       = '0;
    endtask

    task automatic compare_outputs();
        req_t h;
        h = (model_q.size() != 0) ? model_q[0] : '0;
        check("count",     64'(count_o),     64'(model_q.size()));
        check("in_ready",  64'(in_ready_o),  64'((model_q.size() < DEPTH) && !flush_i));
        check("vec_req",   64'(vec_req_o),   64'(model_q.size() != 0));
        check("vec_we",    64'(vec_we_o),    64'(h.we));
        check("vec_index", 64'(vec_index_o), 64'(h.index));
        check("vec_word",  64'(vec_word_o),  64'(h.word));
        check("vec_way",   64'(vec_way_o),   64'(h.way));
        check("vec_be",    64'(vec_be_o),    64'(h.be));
        check("vec_wdata", vec_wdata_o,      h.wdata);
        check("starve",    64'(starve_o),    64'(model_starve == STARVE_LIMIT));
        check("rsp_valid", 64'(rsp_valid_o), 64'(model_rsp_valid));
        check("rsp_rdata", rsp_rdata_o,
              (model_rsp_valid && !model_rsp.we) ? bank_rdata_i : 64'd0);
        if (model_rsp_valid) begin
            check("rsp_we", 64'(rsp_we_o), 64'(model_rsp.we));
            check("rsp_id", 64'(rsp_id_o), 64'(model_rsp.id));
        end
    endtask

    // Applies the rules of one rising edge using the inputs as driven.
    task automatic model_step();
        bit was_empty = (model_q.size() == 0);
        bit do_push   = in_valid_i && (model_q.size() < DEPTH) && !flush_i;
        bit do_pop    = !was_empty && !vec_stall_i && !flush_i;
        model_rsp_valid = do_pop;
        if (do_pop)  model_rsp = model_q.pop_front();
        if (do_push) model_q.push_back(drv);
        if (flush_i) model_q.delete();
        if (flush_i || do_pop || was_empty) model_starve = 0;
        else if (vec_stall_i && model_starve < STARVE_LIMIT) model_starve++;
    endtask

    // Called at posedge+1 with inputs already driven for this cycle.
    task automatic tick();
        #4;
        compare_outputs();
        @(posedge clk_i);
        model_step();
        #1;
    endtask

    task automatic set_req(input logic [ID_W-1:0] id, input logic we);
        drv.we    = we;
        drv.index = INDEX_W'($urandom);
        drv.word  = WORD_W'($urandom);
        drv.way   = WAY_W'($urandom);
        drv.be    = BE_W'($urandom);
        drv.wdata = {$urandom, $urandom};
        drv.id    = id;
    endtask

    task automatic pulse_reset();
        rst_ni      = 1'b0;
        in_valid_i  = 1'b0;
        flush_i     = 1'b0;
        vec_stall_i = 1'b0;
        model_reset();
        #2;
        compare_outputs();
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
    endtask

    task automatic idle(input int n);
        in_valid_i = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        rst_ni       = 1'b0;
        in_valid_i   = 1'b0;
        vec_stall_i  = 1'b0;
        flush_i      = 1'b0;
        bank_rdata_i = '0;
        drv          = '0;
        model_reset();

        phase = "reset";
        #12;
        compare_outputs();
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        tick();

        // Back-to-back pushes of ids 1,2,3 with the arbiter free
        phase = "seq123";
        bank_rdata_i = 64'h0123_4567_89AB_CDEF;
        for (int i = 1; i <= 3; i++) begin
            in_valid_i = 1'b1;
            set_req(ID_W'(i), i[0]);
            tick();
        end
        idle(4);

        // Fill to capacity, hold in_valid, then release one grant
        phase = "full";
        vec_stall_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_valid_i = 1'b1;
            set_req(ID_W'(8 + i), 1'b1);
            tick();
        end
        vec_stall_i = 1'b0;
        set_req(ID_W'(14), 1'b0);
        tick();
        vec_stall_i = 1'b1;
        tick();
        vec_stall_i = 1'b0;
        idle(6);

        // Starvation: 16 stalled cycles with one entry, then release
        phase = "starve";
        vec_stall_i = 1'b1;
        in_valid_i  = 1'b1;
        set_req(ID_W'(7), 1'b0);
        tick();
        idle(16);
        vec_stall_i = 1'b0;
        idle(3);

        // Read completion with bank data
        phase = "read5";
        bank_rdata_i = 64'hDEAD_BEEF_CAFE_F00D;
        in_valid_i   = 1'b1;
        set_req(ID_W'(5), 1'b0);
        tick();
        idle(3);

        // Push and pop together at occupancy 2 across several pointer wraps
        phase = "wrap";
        vec_stall_i = 1'b1;
        for (int i = 0; i < 2; i++) begin
            in_valid_i = 1'b1;
            set_req(ID_W'(i), i[0]);
            tick();
        end
        vec_stall_i = 1'b0;
        for (int i = 2; i < 11; i++) begin
            in_valid_i = 1'b1;
            set_req(ID_W'(i), i[0]);
            bank_rdata_i = {$urandom, $urandom};
            tick();
        end
        idle(3);

        // Flush with 3 entries right after a grant
        phase = "flush";
        vec_stall_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid_i = 1'b1;
            set_req(ID_W'(i + 3), 1'b0);
            tick();
        end
        in_valid_i  = 1'b0;
        vec_stall_i = 1'b0;
        tick();
        flush_i    = 1'b1;
        in_valid_i = 1'b1;
        set_req(ID_W'(15), 1'b0);
        tick();
        flush_i    = 1'b0;
        in_valid_i = 1'b0;
        idle(2);

        // Reset pulse in the middle of traffic, with a grant pending
        phase = "midreset";
        for (int i = 0; i < 3; i++) begin
            in_valid_i = 1'b1;
            set_req(ID_W'(i + 9), 1'b0);
            tick();
        end
        pulse_reset();
        idle(2);

        // Randomized traffic
        phase = "random";
        for (int i = 0; i < 3000; i++) begin
            in_valid_i   = ($urandom_range(0, 9) < 7);
            vec_stall_i  = ($urandom_range(0, 9) < 4);
            flush_i      = ($urandom_range(0, 99) < 3);
            bank_rdata_i = {$urandom, $urandom};
            set_req(ID_W'($urandom), 1'($urandom));
            if ($urandom_range(0, 199) == 0) pulse_reset();
            else tick();
            // Occasional long stalls to exercise starvation saturation
            if ($urandom_range(0, 299) == 0) begin
                in_valid_i  = 1'b0;
                flush_i     = 1'b0;
                vec_stall_i = 1'b1;
                for (int k = 0; k < 20; k++) tick();
            end
        end
        flush_i     = 1'b0;
        vec_stall_i = 1'b0;
        idle(6);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
